// File: rtl/fric_master_arbiter_pkg.sv
// Shared fric field widths, transaction codes and arbiter types.
// Used by fric_master_arbiter and its round-robin picker.
package fric_master_arbiter_pkg;

    localparam int unsigned FRIC_TYPE_W = 4;
    localparam int unsigned FRIC_PORT_W = 4;
    localparam int unsigned FRIC_ADDR_W = 8;
    localparam int unsigned FRIC_DATA_W = 16;

    localparam logic [3:0] FRIC_TYPE_NOP = 4'h0;
    localparam logic [3:0] FRIC_TYPE_RD  = 4'h1;
    localparam logic [3:0] FRIC_TYPE_WR  = 4'h2;

    localparam logic [15:0] FRIC_TIMEOUT_DATA = 16'hDEAD;

    typedef struct packed {
        logic [3:0]  typ;
        logic [3:0]  port;
        logic [7:0]  addr;
        logic [15:0] wdat;
    } fric_txn_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } arb_state_t;

endpackage

// File: rtl/fric_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or above i_ptr,
// wrapping from NREQ-1 back to 0.
module fric_rr_pick #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] i_pending,
    input  logic [PTRW-1:0] i_ptr,
    output logic [PTRW-1:0] o_grant,
    output logic            o_any
);

    always_comb begin
        int unsigned idx;
        o_grant = '0;
        // Walk from the farthest offset down so the nearest pending slot wins.
        for (int unsigned k = NREQ; k > 0; k--) begin
            idx = (32'(i_ptr) + k - 1) % NREQ;
            if (i_pending[PTRW'(idx)]) o_grant = PTRW'(idx);
        end
    end

    assign o_any = |i_pending;

endmodule

// File: rtl/fric_master_arbiter.sv
// Shares the fric_client master port among NREQ requesters, one outstanding
// transaction at a time. Define FRIC_ARB_TIMEOUT_EN to bound the reply wait.
module fric_master_arbiter
    import fric_master_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int PTRW    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*NREQ-1:0]  req_type,
    input  logic [4*NREQ-1:0]  req_port,
    input  logic [8*NREQ-1:0]  req_addr,
    input  logic [16*NREQ-1:0] req_wdat,
    input  logic [NREQ-1:0]    req_tstb,
    output logic [NREQ-1:0]    req_trdy,
    output logic [NREQ-1:0]    req_rstb,
    output logic [15:0]        req_rdat,
    output logic               req_rerr,
    output logic [3:0]         master_type,
    output logic [3:0]         master_port,
    output logic [7:0]         master_addr,
    output logic [15:0]        master_wdat,
    output logic               master_tstb,
    input  logic               master_trdy,
    input  logic               master_rstb,
    input  logic [15:0]        master_rdat,
    output logic               err_stray
);

    arb_state_t      r_state, w_state_nxt;
    fric_txn_t       r_slot [NREQ];
    fric_txn_t       r_mst;
    logic [NREQ-1:0] r_pending, r_trdy, r_rstb, w_capture, w_clr;
    logic [PTRW-1:0] r_ptr, r_grant, w_pick_grant, w_ptr_nxt;
    logic            w_pick_any, w_load_grant, w_reply, w_timeout;
    logic            r_mst_tstb, r_err_stray;
    logic [15:0]     r_rdat, w_reply_data;

    fric_rr_pick #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_grant   (w_pick_grant),
        .o_any     (w_pick_any)
    );

    assign w_capture    = req_tstb & r_trdy;
    assign w_reply      = (r_state == ST_WAIT) && (master_rstb || w_timeout);
    assign w_clr        = w_reply ? (NREQ'(1) << r_grant) : '0;
    assign w_ptr_nxt    = (r_grant == PTRW'(NREQ - 1)) ? '0 : r_grant + PTRW'(1);
    assign w_reply_data = master_rstb ? master_rdat : FRIC_TIMEOUT_DATA;

    always_comb begin
        w_state_nxt  = r_state;
        w_load_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (master_trdy && w_pick_any) begin
                    w_state_nxt  = ST_ISSUE;
                    w_load_grant = 1'b1;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_reply) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_trdy      <= '1;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_mst       <= '0;
            r_mst_tstb  <= 1'b0;
            r_rstb      <= '0;
            r_rdat      <= '0;
            r_err_stray <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) r_slot[i] <= '0;
        end else begin
            // Replying slot's trdy is still 0, so capture and clear never collide.
            r_pending <= (r_pending | w_capture) & ~w_clr;
            r_trdy    <= (r_trdy & ~w_capture) | w_clr;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (w_capture[i])
                    r_slot[i] <= {req_type[4*i +: 4], req_port[4*i +: 4],
                                  req_addr[8*i +: 8], req_wdat[16*i +: 16]};
            end
            if (w_load_grant) r_grant <= w_pick_grant;
            r_mst_tstb <= (r_state == ST_ISSUE);
            if (r_state == ST_ISSUE) r_mst <= r_slot[r_grant];
            r_rstb <= w_clr;
            if (w_reply) begin
                r_rdat <= w_reply_data;
                r_ptr  <= w_ptr_nxt;
            end
            if (master_rstb && (r_state != ST_WAIT)) r_err_stray <= 1'b1;
        end
    end

`ifdef FRIC_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] r_tcnt;
    logic          r_rerr;

    assign w_timeout = (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
            r_rerr <= 1'b0;
        end else begin
            r_tcnt <= (r_state == ST_WAIT) ? r_tcnt + TW'(1) : '0;
            r_rerr <= w_reply && !master_rstb;
        end
    end

    assign req_rerr = r_rerr;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign req_rerr         = 1'b0;
`endif

    assign req_trdy    = r_trdy;
    assign req_rstb    = r_rstb;
    assign req_rdat    = r_rdat;
    assign master_type = r_mst.typ;
    assign master_port = r_mst.port;
    assign master_addr = r_mst.addr;
    assign master_wdat = r_mst.wdat;
    assign master_tstb = r_mst_tstb;
    assign err_stray   = r_err_stray;

endmodule

// File: tb/tb_fric_master_arbiter.sv
// Self-checking bench for fric_master_arbiter: directed vectors, corner-case
// sequences and a randomized run against a slot/pointer reference model.
module tb_fric_master_arbiter;
    import fric_master_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int PTRW = 2;
`ifdef FRIC_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [4*NREQ-1:0]    req_type, req_port;
    logic [8*NREQ-1:0]    req_addr;
    logic [16*NREQ-1:0]   req_wdat;
    logic [NREQ-1:0]      req_tstb, req_trdy, req_rstb;
    logic [15:0]          req_rdat;
    logic                 req_rerr;
    logic [3:0]           master_type, master_port;
    logic [7:0]           master_addr;
    logic [15:0]          master_wdat;
    logic                 master_tstb, master_trdy, master_rstb;
    logic [15:0]          master_rdat;
    logic                 err_stray;

    int n_chk = 0, n_fail = 0, cyc = 0, n_illegal = 0;

    always #5 clk = ~clk;

    fric_master_arbiter #(.NREQ(NREQ), .PTRW(PTRW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_type(req_type), .req_port(req_port), .req_addr(req_addr), .req_wdat(req_wdat),
        .req_tstb(req_tstb), .req_trdy(req_trdy), .req_rstb(req_rstb),
        .req_rdat(req_rdat), .req_rerr(req_rerr),
        .master_type(master_type), .master_port(master_port), .master_addr(master_addr),
        .master_wdat(master_wdat), .master_tstb(master_tstb), .master_trdy(master_trdy),
        .master_rstb(master_rstb), .master_rdat(master_rdat), .err_stray(err_stray)
    );

    // Strobing a slot that is not ready is illegal; only the deliberate one may occur.
    always @(posedge clk) if (!rst && |(req_tstb & ~req_trdy)) n_illegal++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic strobe(input int i, input fric_txn_t t);
        req_type[4*i +: 4]  = t.typ;
        req_port[4*i +: 4]  = t.port;
        req_addr[8*i +: 8]  = t.addr;
        req_wdat[16*i +: 16] = t.wdat;
        req_tstb[i] = 1'b1;
    endtask

    task automatic wait_tstb(input int lim);
        for (int k = 0; k < lim && !master_tstb; k++) step();
    endtask

    task automatic do_txn(input int idx, input logic [7:0] addr);
        wait_tstb(20);
        chk("txn_issue", master_tstb, 1);
        chk("txn_addr", master_addr, addr);
        master_rstb = 1'b1;
        master_rdat = {addr, ~addr};
        step();
        master_rstb = 1'b0;
        chk("txn_rstb", req_rstb, 64'(1) << idx);
        chk("txn_rdat", req_rdat, {addr, ~addr});
    endtask

    function automatic int first_at(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    typedef struct {
        int          idx;
        fric_txn_t   t;
        logic [15:0] rd;
    } vec_t;

    vec_t vt[5];

    // reference model state for the randomized phase
    logic [NREQ-1:0] m_free, m_pend, elig;
    int              m_cap[NREQ];
    fric_txn_t       m_slot[NREQ];
    int              m_ptr, m_oslot, m_redge, g;
    bit              m_out, quiet;
    logic [15:0]     m_rdat;
    fric_txn_t       tx;

    initial begin
        vt[0] = '{1, '{FRIC_TYPE_RD, 4'h3, 8'h10, 16'h0000}, 16'h1234};
        vt[1] = '{0, '{FRIC_TYPE_WR, 4'hF, 8'hFF, 16'hFFFF}, 16'h0001};
        vt[2] = '{2, '{FRIC_TYPE_WR, 4'h0, 8'h00, 16'hA55A}, 16'hFFFF};
        vt[3] = '{1, '{4'hF,         4'h7, 8'h81, 16'h8001}, 16'h0000};
        vt[4] = '{3, '{FRIC_TYPE_RD, 4'h9, 8'h3C, 16'h1357}, 16'hBEEF};

        rst = 1'b1;
        req_type = '0; req_port = '0; req_addr = '0; req_wdat = '0; req_tstb = '0;
        master_trdy = 1'b0; master_rstb = 1'b0; master_rdat = '0;
        step(); step();
        chk("rst_trdy", req_trdy, 4'hF);
        chk("rst_tstb", master_tstb, 0);
        chk("rst_rstb", req_rstb, 0);
        chk("rst_master", {master_type, master_port, master_addr, master_wdat}, 0);
        chk("rst_rdat", req_rdat, 0);
        chk("rst_err", {err_stray, req_rerr}, 0);
        rst = 1'b0;
        master_trdy = 1'b1;
        step();

        // single-request vectors: 3-cycle issue latency, 1-cycle reply latency
        for (int v = 0; v < 5; v++) begin
            strobe(vt[v].idx, vt[v].t);
            step();
            req_tstb = '0;
            chk("vec_trdy_low", req_trdy, 4'hF & ~(4'(1) << vt[v].idx));
            chk("vec_tstb_early", master_tstb, 0);
            step();
            chk("vec_tstb_early2", master_tstb, 0);
            step();
            chk("vec_tstb", master_tstb, 1);
            chk("vec_fields", {master_type, master_port, master_addr, master_wdat}, vt[v].t);
            step();
            chk("vec_tstb_pulse", master_tstb, 0);
            chk("vec_hold", master_addr, vt[v].t.addr);
            master_rstb = 1'b1;
            master_rdat = vt[v].rd;
            step();
            master_rstb = 1'b0;
            chk("vec_rstb", req_rstb, 4'(1) << vt[v].idx);
            chk("vec_rdat", req_rdat, vt[v].rd);
            chk("vec_rerr", req_rerr, 0);
            chk("vec_trdy_back", req_trdy, 4'hF);
            step();
            chk("vec_rstb_pulse", req_rstb, 0);
        end

        // round-robin from ptr 0; slot 0 re-strobes after its reply
        for (int i = 0; i < NREQ; i++) strobe(i, '{FRIC_TYPE_RD, 4'h1, 8'(8'h40 + i), 16'h0});
        step();
        req_tstb = '0;
        do_txn(0, 8'h40);
        strobe(0, '{FRIC_TYPE_RD, 4'h1, 8'h50, 16'h0});
        step();
        req_tstb = '0;
        do_txn(1, 8'h41);
        do_txn(2, 8'h42);
        do_txn(3, 8'h43);
        do_txn(0, 8'h50);

        // backpressure: nothing issues while master_trdy is low
        master_trdy = 1'b0;
        strobe(1, '{FRIC_TYPE_WR, 4'h2, 8'h61, 16'h1111});
        strobe(2, '{FRIC_TYPE_WR, 4'h2, 8'h62, 16'h2222});
        step();
        req_tstb = '0;
        quiet = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (master_tstb) quiet = 1'b0;
        end
        chk("bp_no_issue", quiet, 1);
        master_trdy = 1'b1;
        for (int k = 0; k < 2 && !master_tstb; k++) step();
        chk("bp_resume", master_tstb, 1);
        do_txn(1, 8'h61);
        do_txn(2, 8'h62);

        // randomized run against the reference model
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_free = '1; m_pend = '0; m_ptr = 0; m_out = 1'b0;
        for (int i = 0; i < NREQ; i++) m_cap[i] = 0;
        for (int n = 0; n < 3400; n++) begin
            if (m_out && m_redge == cyc) begin
                chk("rand_rstb", req_rstb, 4'(1) << m_oslot);
                chk("rand_rdat", req_rdat, m_rdat);
                m_free[m_oslot] = 1'b1;
                m_pend[m_oslot] = 1'b0;
                m_ptr = (m_oslot + 1) % NREQ;
                m_out = 1'b0;
            end else begin
                chk("rand_rstb_idle", req_rstb, 0);
            end
            if (master_tstb) begin
                // the grant decision was taken one edge earlier, on slots captured before it
                elig = '0;
                for (int i = 0; i < NREQ; i++) if (m_pend[i] && m_cap[i] <= cyc - 2) elig[i] = 1'b1;
                chk("rand_overlap", m_out, 0);
                chk("rand_eligible", |elig, 1);
                g = first_at(elig, m_ptr);
                if (g >= 0) begin
                    chk("rand_issue", {master_type, master_port, master_addr, master_wdat}, m_slot[g]);
                    m_out = 1'b1;
                    m_oslot = g;
                    m_redge = cyc + 1 + int'($urandom_range(0, 4));
                    m_rdat = 16'($urandom);
                end
            end
            chk("rand_trdy", req_trdy, m_free);
            if (n >= 3000 && m_free == '1 && !m_out) break;
            master_rstb = m_out && (m_redge == cyc + 1);
            master_rdat = master_rstb ? m_rdat : 16'($urandom);
            master_trdy = ($urandom_range(0, 3) != 0);
            req_tstb = '0;
            if (n < 3000) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (m_free[i] && $urandom_range(0, 3) == 0) begin
                        tx = fric_txn_t'($urandom);
                        strobe(i, tx);
                        m_slot[i] = tx;
                        m_free[i] = 1'b0;
                        m_pend[i] = 1'b1;
                        m_cap[i] = cyc + 1;
                    end
                end
            end
            step();
        end
        req_tstb = '0;
        master_rstb = 1'b0;
        master_trdy = 1'b1;
        chk("rand_drain", req_trdy, 4'hF);
        chk("rand_no_stray", err_stray, 0);

        // stray reply in IDLE sets a sticky error and is not delivered
        master_rstb = 1'b1;
        step();
        master_rstb = 1'b0;
        chk("stray_set", err_stray, 1);
        chk("stray_dropped", req_rstb, 0);
        step(); step(); step();
        chk("stray_sticky", err_stray, 1);

        // strobe to a full slot leaves its contents alone
        master_trdy = 1'b0;
        strobe(2, '{FRIC_TYPE_WR, 4'h5, 8'h22, 16'hC0DE});
        step();
        req_tstb = '0;
        chk("illegal_trdy", req_trdy[2], 0);
        strobe(2, '{FRIC_TYPE_RD, 4'h6, 8'h99, 16'hBAD0});
        step();
        req_tstb = '0;
        master_trdy = 1'b1;
        do_txn(2, 8'h22);
        chk("illegal_wdat", master_wdat, 16'hC0DE);

`ifdef FRIC_ARB_TIMEOUT_EN
        // ptr is 3 after slot 2's reply: slot 3 first, then wrap to slot 1
        strobe(1, '{FRIC_TYPE_RD, 4'h1, 8'h71, 16'h0});
        strobe(3, '{FRIC_TYPE_RD, 4'h1, 8'h73, 16'h0});
        step();
        req_tstb = '0;
        wait_tstb(10);
        chk("tmo_issue_addr", master_addr, 8'h73);
        quiet = 1'b1;
        for (int k = 0; k < TMO - 1; k++) begin
            step();
            if (req_rstb != 0) quiet = 1'b0;
        end
        chk("tmo_not_early", quiet, 1);
        step();
        chk("tmo_rstb", req_rstb, 4'b1000);
        chk("tmo_rerr", req_rerr, 1);
        chk("tmo_rdat", req_rdat, 16'hDEAD);
        do_txn(1, 8'h71);
        chk("tmo_next_rerr", req_rerr, 0);
`endif

        // reset while waiting for a reply discards the transaction
        strobe(0, '{FRIC_TYPE_WR, 4'h4, 8'h0C, 16'h7777});
        step();
        req_tstb = '0;
        wait_tstb(10);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rwait_trdy", req_trdy, 4'hF);
        chk("rwait_tstb", master_tstb, 0);
        chk("rwait_err_clr", err_stray, 0);
        quiet = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (req_rstb != 0 || master_tstb) quiet = 1'b0;
        end
        chk("rwait_quiet", quiet, 1);
        master_rstb = 1'b1;
        step();
        master_rstb = 1'b0;
        chk("rwait_late_stray", err_stray, 1);
        chk("rwait_late_dropped", req_rstb, 0);
        strobe(0, '{FRIC_TYPE_RD, 4'h4, 8'h0D, 16'h0});
        step();
        req_tstb = '0;
        do_txn(0, 8'h0D);

        chk("illegal_strobes", n_illegal, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
